// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED sequencer.
//   mode_e        : sequencing mode held in the MODE register
//   ADDR_*        : CPU register map (2-bit address)
//   *_RST         : reset values for PATTERN, PERIOD and the current frame
package led_seq_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    BLINK  = 2'd1,
    CHASE  = 2'd2,
    COUNT  = 2'd3
  } mode_e;

  localparam logic [1:0] ADDR_PATTERN = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_FRAME   = 2'd3;

  localparam logic [7:0] PATTERN_RST  = 8'hFF;
  localparam logic [7:0] PERIOD_RST   = 8'h0F;
  localparam logic [7:0] FRAME_RST    = 8'hFF;

endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running prescaler, 0..TICK_DIV-1 with wrap.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : restart the count at 0 (takes priority over counting)
//   enable     : count only while high; held at 0 otherwise
//   tick       : high for the one cycle the count equals TICK_DIV-1
module tick_divider #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear || !enable) cnt <= '0;
    else if (cnt == LAST)          cnt <= '0;
    else                           cnt <= cnt + CW'(1);
  end

  // Gated by enable so a disabled divider can never leak a tick.
  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: CPU-programmable driver for the LED register write port.
//   clk, reset     : system clock, synchronous active-high reset
//   writeEnable    : CPU write strobe (one cycle per write)
//   readEnable     : CPU read strobe, readData valid the following cycle
//   addr           : 0 PATTERN, 1 MODE, 2 PERIOD, 3 FRAME (read-only)
//   writeData      : CPU write data
//   readData       : registered read data, holds between reads
//   ledWriteEnable : single-cycle write pulse to the LED register
//   ledWriteData   : frame presented with the pulse, holds between pulses
//   running        : MODE != MANUAL
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeEnable,
  input  logic              readEnable,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              ledWriteEnable,
  output logic [DATA_W-1:0] ledWriteData,
  output logic              running
);

  logic [DATA_W-1:0] pattern, period, frame, stepCnt, nextFrame;
  mode_e             mode;
  logic              tick, step, clr;
  logic              wrPat, wrMode, wrPer;

  assign wrPat  = writeEnable && (addr == ADDR_PATTERN);
  assign wrMode = writeEnable && (addr == ADDR_MODE);
  assign wrPer  = writeEnable && (addr == ADDR_PERIOD);
  // Any register write restarts the timebase so the next step is a full
  // period after the CPU's change.
  assign clr    = wrPat || wrMode || wrPer;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (clr),
    .enable (mode != MANUAL),
    .tick   (tick)
  );

  assign step    = tick && (stepCnt == period);
  assign running = (mode != MANUAL);

  always_comb begin
    nextFrame = frame;
    case (mode)
      BLINK:   nextFrame = ~frame;
      CHASE:   nextFrame = {frame[DATA_W-2:0], frame[DATA_W-1]};
      COUNT:   nextFrame = frame + DATA_W'(1);
      default: nextFrame = frame;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern        <= DATA_W'(PATTERN_RST);
      period         <= DATA_W'(PERIOD_RST);
      frame          <= DATA_W'(FRAME_RST);
      mode           <= MANUAL;
      stepCnt        <= '0;
      ledWriteEnable <= 1'b0;
      ledWriteData   <= DATA_W'(FRAME_RST);
      readData       <= '0;
    end else begin
      ledWriteEnable <= 1'b0;

      // Read mux sees pre-write register values, so a read and write to the
      // same address in one cycle returns the old contents.
      if (readEnable) begin
        case (addr)
          ADDR_PATTERN: readData <= pattern;
          ADDR_MODE:    readData <= {{(DATA_W-2){1'b0}}, mode};
          ADDR_PERIOD:  readData <= period;
          default:      readData <= frame;
        endcase
      end

      if (!running || clr)  stepCnt <= '0;
      else if (tick)        stepCnt <= (stepCnt == period) ? '0 : stepCnt + DATA_W'(1);

      // CPU writes own the LED port; a step coinciding with any write
      // (including the ignored FRAME address) is dropped, never deferred.
      if (wrPat) begin
        pattern        <= writeData;
        frame          <= writeData;
        ledWriteEnable <= 1'b1;
        ledWriteData   <= writeData;
      end else if (wrMode) begin
        mode           <= mode_e'(writeData[1:0]);
        frame          <= pattern;
        ledWriteEnable <= 1'b1;
        ledWriteData   <= pattern;
      end else if (wrPer) begin
        period         <= writeData;
      end else if (step && !writeEnable) begin
        frame          <= nextFrame;
        ledWriteEnable <= 1'b1;
        ledWriteData   <= nextFrame;
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;
  import led_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       writeEnable = 1'b0, readEnable = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] writeData = 8'h00;
  logic [7:0] readData, ledWriteData;
  logic       ledWriteEnable, running;

  led_sequencer #(.TICK_DIV(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .writeEnable(writeEnable), .readEnable(readEnable),
    .addr(addr), .writeData(writeData), .readData(readData),
    .ledWriteEnable(ledWriteEnable), .ledWriteData(ledWriteData), .running(running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] data; } pulse_t;
  // kind: 0 readData, 1 ledWriteData, 2 running
  typedef struct { int cyc; int kind; logic [7:0] val; } lvl_t;

  pulse_t pq[$];
  lvl_t   lq[$];
  bit     fin = 1'b0;
  int     nchk = 0, nerr = 0;

  // Monitor: pops expectations and compares at the falling edge.
  always @(negedge clk) begin
    pulse_t p;
    lvl_t   l;
    logic [7:0] act;
    while (pq.size() > 0 && pq[0].cyc < cyc) begin
      p = pq.pop_front();
      nchk++; nerr++;
      $display("FAIL missed_pulse cyc=%0d got none, expected data %h", p.cyc, p.data);
    end
    if (ledWriteEnable) begin
      nchk++;
      if (pq.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_pulse cyc=%0d got data %h, expected no pulse", cyc, ledWriteData);
      end else begin
        p = pq.pop_front();
        if (p.cyc != cyc || p.data != ledWriteData) begin
          nerr++;
          $display("FAIL pulse cyc=%0d data=%h, expected cyc=%0d data=%h", cyc, ledWriteData, p.cyc, p.data);
        end
      end
    end
    while (lq.size() > 0 && lq[0].cyc <= cyc) begin
      l = lq.pop_front();
      nchk++;
      case (l.kind)
        0:       act = readData;
        1:       act = ledWriteData;
        default: act = {7'd0, running};
      endcase
      if (l.cyc != cyc || act != l.val) begin
        nerr++;
        $display("FAIL level kind=%0d cyc=%0d got %h, expected %h at cyc %0d", l.kind, cyc, act, l.val, l.cyc);
      end
    end
    if (fin) begin
      nchk++;
      if (pq.size() != 0 || lq.size() != 0) begin
        nerr++;
        $display("FAIL leftover got %0d pulses %0d levels pending, expected 0", pq.size(), lq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic step1();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step1();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step1();
  endtask

  task automatic pexp(input int c, input logic [7:0] d);
    pq.push_back('{c, d});
  endtask

  task automatic lexp(input int c, input int k, input logic [7:0] v);
    lq.push_back('{c, k, v});
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, output int c);
    c = cyc;
    writeEnable = 1'b1; addr = a; writeData = d;
    step1();
    writeEnable = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e);
    lexp(cyc + 1, 0, e);
    readEnable = 1'b1; addr = a;
    step1();
    readEnable = 1'b0;
  endtask

  task automatic rd_reset_state();
    rd(ADDR_PATTERN, 8'hFF);
    rd(ADDR_MODE,    8'h00);
    rd(ADDR_PERIOD,  8'h0F);
    rd(ADDR_FRAME,   8'hFF);
  endtask

  initial begin
    int w, w2;
    idle(3);
    reset = 1'b0;
    // 1: reset state and idle
    lexp(cyc, 0, 8'h00);
    lexp(cyc, 1, 8'hFF);
    lexp(cyc, 2, 8'h00);
    idle(50);
    lexp(cyc, 1, 8'hFF);
    rd_reset_state();

    // 2: MANUAL pass-through
    wr(ADDR_PATTERN, 8'hA5, w);
    pexp(w + 1, 8'hA5);
    idle(100);
    rd(ADDR_FRAME, 8'hA5);
    // simultaneous read+write of PATTERN returns the old value
    w = cyc;
    lexp(w + 1, 0, 8'hA5);
    pexp(w + 1, 8'h5A);
    readEnable = 1'b1; writeEnable = 1'b1; addr = ADDR_PATTERN; writeData = 8'h5A;
    step1();
    readEnable = 1'b0; writeEnable = 1'b0;
    idle(5);

    // 3: CHASE, PERIOD=1 -> 8-cycle steps
    wr(ADDR_PATTERN, 8'h81, w); pexp(w + 1, 8'h81);
    wr(ADDR_PERIOD, 8'h01, w);
    wr(ADDR_MODE, 8'h02, w);
    pexp(w + 1, 8'h81); pexp(w + 9, 8'h03); pexp(w + 17, 8'h06);
    pexp(w + 25, 8'h0C); pexp(w + 33, 8'h18);
    lexp(w + 2, 2, 8'h01);
    wait_until(w + 34);
    wr(ADDR_MODE, 8'h00, w2); pexp(w2 + 1, 8'h81);
    idle(20);

    // 4: COUNT wrap, PERIOD=0 -> 4-cycle steps
    wr(ADDR_PATTERN, 8'hFE, w); pexp(w + 1, 8'hFE);
    wr(ADDR_PERIOD, 8'h00, w);
    wr(ADDR_MODE, 8'h03, w);
    pexp(w + 1, 8'hFE); pexp(w + 5, 8'hFF); pexp(w + 9, 8'h00); pexp(w + 13, 8'h01);
    wait_until(w + 14);
    wr(ADDR_MODE, 8'h00, w2); pexp(w2 + 1, 8'hFE);
    idle(10);

    // 5: BLINK collision: PATTERN write in a step-condition cycle wins
    wr(ADDR_PATTERN, 8'h0F, w); pexp(w + 1, 8'h0F);
    wr(ADDR_MODE, 8'h01, w);
    pexp(w + 1, 8'h0F); pexp(w + 5, 8'hF0);
    wait_until(w + 8);
    wr(ADDR_PATTERN, 8'h3C, w2);
    pexp(w2 + 1, 8'h3C); pexp(w2 + 5, 8'hC3);
    wait_until(w2 + 6);
    wr(ADDR_MODE, 8'h00, w2); pexp(w2 + 1, 8'h3C);
    idle(10);

    // 6: reset one cycle before a CHASE step
    wr(ADDR_PATTERN, 8'h81, w); pexp(w + 1, 8'h81);
    wr(ADDR_PERIOD, 8'h01, w);
    wr(ADDR_MODE, 8'h02, w);
    pexp(w + 1, 8'h81); pexp(w + 9, 8'h03);
    wait_until(w + 15);
    reset = 1'b1;
    step1();
    reset = 1'b0;
    lexp(cyc, 1, 8'hFF);
    lexp(cyc, 2, 8'h00);
    lexp(cyc, 0, 8'h00);
    idle(100);
    rd_reset_state();
    idle(3);
    fin = 1'b1;
  end

endmodule
